// File: rtl/ni_config_arbiter.sv
// ni_config_arbiter
//   Shares one ni_config register bus between NUM_REQ requesters using a
//   round-robin grant. One transaction is in flight at a time:
//   IDLE (pick a requester and latch it), ACCESS (drive the slave),
//   RESP (one-cycle ack/err pulse to the granted requester).
//
//   Optional feature: define NI_CONFIG_ARB_TIMEOUT_EN to add a slave
//   watchdog that ends an ACCESS with err status after TIMEOUT_CYCLES
//   cycles without bus_ack/bus_err. Without it ACCESS waits indefinitely.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_addr/req_data_in       NUM_REQ x 32-bit requester address / write data
//   req_we, req_en             per-requester write enable / request
//   req_data_out               NUM_REQ x 32-bit read data (valid with pulse)
//   req_ack, req_err           per-requester completion strobes
//   bus_addr/bus_we/bus_en/bus_data_in   shared slave request
//   bus_data_out/bus_ack/bus_err         shared slave response
module ni_config_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ-1:0]     req_en,
  input  logic [NUM_REQ*32-1:0]  req_data_in,
  output logic [NUM_REQ*32-1:0]  req_data_out,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [31:0]            bus_addr,
  output logic                   bus_we,
  output logic                   bus_en,
  output logic [31:0]            bus_data_in,
  input  logic [31:0]            bus_data_out,
  input  logic                   bus_ack,
  input  logic                   bus_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Parameters outside their supported ranges elaborate into a marker block.
  if ((NUM_REQ < 1) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_param_out_of_range
  end

  logic [1:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [31:0]   lat_addr;
  logic          lat_we;
  logic [31:0]   lat_data;
  logic [31:0]   resp_data;
  logic          resp_err;
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
  logic [7:0]    wd_cnt;
`endif

  logic [GW-1:0] cand;
  logic [GW-1:0] pick;
  logic          found;
  logic [31:0]   pick_addr;
  logic          pick_we;
  logic [31:0]   pick_data;

  // Round-robin search: walk indices starting just after last_grant, wrapping.
  always_comb begin
    cand  = last_grant;
    pick  = last_grant;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_en[cand]) begin
        found = 1'b1;
        pick  = cand;
      end else begin
        found = found;
      end
    end
  end

  // Select the chosen requester's address, write enable and write data.
  always_comb begin
    pick_addr = 32'd0;
    pick_we   = 1'b0;
    pick_data = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        pick_addr = req_addr[32*i +: 32];
        pick_we   = req_we[i];
        pick_data = req_data_in[32*i +: 32];
      end else begin
        pick_addr = pick_addr;
      end
    end
  end

  // Transaction FSM with request latch and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      lat_addr   <= 32'd0;
      lat_we     <= 1'b0;
      lat_data   <= 32'd0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
      wd_cnt     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            lat_addr <= pick_addr;
            lat_we   <= pick_we;
            lat_data <= pick_data;
            state    <= ACCESS;
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
            wd_cnt   <= 8'd0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (bus_ack || bus_err) begin
            // err dominates; a simultaneous ack+err returns zero data
            resp_err  <= bus_err;
            resp_data <= (bus_ack && bus_err) ? 32'd0 : bus_data_out;
            state     <= RESP;
          end
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
          else if ((wd_cnt + 8'd1) >= 8'(TIMEOUT_CYCLES)) begin
            // this silent cycle brings the count to the limit
            resp_err  <= 1'b1;
            resp_data <= 32'd0;
            wd_cnt    <= wd_cnt + 8'd1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`else
          else begin
            state <= ACCESS;
          end
`endif
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side outputs are only non-zero while the access is in progress.
  always_comb begin
    bus_en      = (state == ACCESS);
    bus_we      = (state == ACCESS) ? lat_we   : 1'b0;
    bus_addr    = (state == ACCESS) ? lat_addr : 32'd0;
    bus_data_in = (state == ACCESS) ? lat_data : 32'd0;
  end

  // Response pulse and data go only to the granted slice during RESP.
  always_comb begin
    req_ack      = '0;
    req_err      = '0;
    req_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == RESP) && (grant == GW'(i))) begin
        req_ack[i]              = !resp_err;
        req_err[i]              = resp_err;
        req_data_out[32*i +: 32] = resp_data;
      end else begin
        req_ack[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ni_config_arbiter.sv
// Self-checking bench for ni_config_arbiter (NUM_REQ=2): directed table,
// hand-written corner sequences, then randomized traffic vs. a
// transaction-level reference model.
module tb_ni_config_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N*32-1:0]  req_addr, req_data_in, req_data_out;
  logic [N-1:0]     req_we, req_en, req_ack, req_err;
  logic [31:0]      bus_addr, bus_data_in, bus_data_out;
  logic             bus_we, bus_en, bus_ack, bus_err;

  logic             auto_slave, s_ack, s_err;
  logic [31:0]      s_data;
  assign bus_ack      = auto_slave ? bus_en : s_ack;
  assign bus_err      = auto_slave ? 1'b0 : s_err;
  assign bus_data_out = auto_slave ? 32'h0000_0042 : s_data;

  ni_config_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_we(req_we), .req_en(req_en),
    .req_data_in(req_data_in), .req_data_out(req_data_out),
    .req_ack(req_ack), .req_err(req_err),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".bus_en"}, 64'(bus_en), 64'd0);
    chk({tag, ".bus_we"}, 64'(bus_we), 64'd0);
    chk({tag, ".bus_addr"}, 64'(bus_addr), 64'd0);
    chk({tag, ".bus_data_in"}, 64'(bus_data_in), 64'd0);
    chk({tag, ".req_ack"}, 64'(req_ack), 64'd0);
    chk({tag, ".req_err"}, 64'(req_err), 64'd0);
    chk({tag, ".req_data_out"}, 64'(req_data_out), 64'd0);
  endtask

  task automatic set_req(input int i, input logic en, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    req_en[i] = en;
    req_we[i] = we;
    req_addr[32*i +: 32]    = addr;
    req_data_in[32*i +: 32] = data;
  endtask

  typedef struct {
    logic [N-1:0] en;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         sack;
    logic         serr;
    logic [31:0]  sdata;
    int           exp_g;
    logic         exp_err;
    logic [31:0]  exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] en, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic sack, input logic serr,
                              input logic [31:0] sdata, input int g, input logic e,
                              input logic [31:0] rd);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.sack = sack; v.serr = serr; v.sdata = sdata;
    v.exp_g = g; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  vec_t vecs[6];

  // reference model: one outstanding transaction record
  int          m_last;
  bit          m_have, m_done, m_we, m_err;
  int          m_g, m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;

  task automatic model_step();
    bit got;
    if (!m_have) begin
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!got && req_en[idx]) begin
          got = 1'b1;
          m_g = idx;
          m_addr = req_addr[32*idx +: 32];
          m_wdata = req_data_in[32*idx +: 32];
          m_we = req_we[idx];
        end
      end
      if (got) begin m_have = 1'b1; m_done = 1'b0; m_age = 0; end
    end else if (!m_done) begin
      if (s_ack || s_err) begin
        m_done = 1'b1;
        m_err = s_err;
        m_rdata = (s_ack && s_err) ? 32'd0 : s_data;
      end
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
      else begin
        m_age++;
        if (m_age >= TO) begin m_done = 1'b1; m_err = 1'b1; m_rdata = 32'd0; end
      end
`endif
    end else begin
      m_last = m_g;
      m_have = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e_ack, e_err, e_dat;
    logic [N-1:0] want;
    int r;
    rst_n = 1'b0; auto_slave = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_data = 32'd0;
    req_en = '0; req_we = '0; req_addr = '0; req_data_in = '0;

    // reset: outputs zero even with requests pending
    set_req(0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
    set_req(1, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    req_en = '0;
    rst_n = 1'b1;

    // table: single transactions from IDLE, slave answers in first ACCESS cycle
    vecs[0] = mk(2'b01, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h5,         0, 1'b0, 32'h5);
    vecs[1] = mk(2'b11, 1'b0, 32'h0000_1000, 32'h10,        1'b1, 1'b0, 32'hA5A5_A5A5, 1, 1'b0, 32'hA5A5_A5A5);
    vecs[2] = mk(2'b11, 1'b0, 32'h0000_2000, 32'h20,        1'b1, 1'b1, 32'hFFFF_FFFF, 0, 1'b1, 32'h0);
    vecs[3] = mk(2'b10, 1'b0, 32'h0000_3000, 32'h30,        1'b0, 1'b1, 32'h0000_1234, 1, 1'b1, 32'h0000_1234);
    vecs[4] = mk(2'b01, 1'b1, 32'h0000_4000, 32'hCAFE_0000, 1'b1, 1'b0, 32'h0,         0, 1'b0, 32'h0);
    vecs[5] = mk(2'b10, 1'b1, 32'h0000_5000, 32'hBEEF_0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        set_req(i, vecs[v].en[i], vecs[v].we, vecs[v].addr + 32'h100 * 32'(i), vecs[v].wdata + 32'(i));
      @(negedge clk);
      chk("tbl.bus_en", 64'(bus_en), 64'd1);
      chk("tbl.bus_addr", 64'(bus_addr), 64'(vecs[v].addr + 32'h100 * 32'(vecs[v].exp_g)));
      chk("tbl.bus_we", 64'(bus_we), 64'(vecs[v].we));
      chk("tbl.bus_data_in", 64'(bus_data_in), 64'(vecs[v].wdata + 32'(vecs[v].exp_g)));
      chk("tbl.early_pulse", 64'(req_ack | req_err), 64'd0);
      s_ack = vecs[v].sack; s_err = vecs[v].serr; s_data = vecs[v].sdata;
      @(negedge clk);
      chk("tbl.req_ack", 64'(req_ack), vecs[v].exp_err ? 64'd0 : (64'd1 << vecs[v].exp_g));
      chk("tbl.req_err", 64'(req_err), vecs[v].exp_err ? (64'd1 << vecs[v].exp_g) : 64'd0);
      chk("tbl.req_data_out", 64'(req_data_out), 64'(vecs[v].exp_rdata) << (32 * vecs[v].exp_g));
      chk("tbl.bus_en_resp", 64'(bus_en), 64'd0);
      req_en = '0; s_ack = 1'b0; s_err = 1'b0;
      @(negedge clk);
      chk_zero("tbl.after");
    end

    // both requesters held: grants alternate, pulse every 3 cycles (last grant was 1)
    auto_slave = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c % 3 == 2) begin
        chk("rr.req_ack", 64'(req_ack), 64'd1 << ((c / 3) % 2));
        chk("rr.req_data_out", 64'(req_data_out), 64'h42 << (32 * ((c / 3) % 2)));
      end else begin
        chk("rr.req_ack", 64'(req_ack), 64'd0);
        chk("rr.req_data_out", 64'(req_data_out), 64'd0);
      end
    end
    req_en = '0;
    auto_slave = 1'b0;

    // silent slave (last grant 1 -> requester 0)
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0C00, 32'h0);
`ifdef NI_CONFIG_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("to.bus_en", 64'(bus_en), 64'd1);
      chk("to.no_pulse", 64'(req_ack | req_err), 64'd0);
    end
    @(negedge clk);
    chk("to.req_err", 64'(req_err), 64'd1);
    chk("to.req_ack", 64'(req_ack), 64'd0);
    chk("to.req_data_out", 64'(req_data_out), 64'd0);
    chk("to.bus_en_resp", 64'(bus_en), 64'd0);
    req_en = '0;
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk("hang.bus_en", 64'(bus_en), 64'd1);
      chk("hang.no_pulse", 64'(req_ack | req_err), 64'd0);
    end
    s_ack = 1'b1; s_data = 32'h0000_0007;
    @(negedge clk);
    chk("hang.req_ack", 64'(req_ack), 64'd1);
    chk("hang.req_data_out", 64'(req_data_out), 64'd7);
    req_en = '0; s_ack = 1'b0;
`endif

    // granted requester drops req_en mid-access; slave acks 2 cycles later
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    chk("drop.bus_addr1", 64'(bus_addr), 64'h100);
    set_req(0, 1'b0, 1'b1, 32'h0000_0BAD, 32'h0);
    @(negedge clk);
    chk("drop.bus_en2", 64'(bus_en), 64'd1);
    chk("drop.bus_addr2", 64'(bus_addr), 64'h100);
    chk("drop.bus_we2", 64'(bus_we), 64'd0);
    @(negedge clk);
    chk("drop.bus_addr3", 64'(bus_addr), 64'h100);
    s_ack = 1'b1; s_data = 32'h5A5A_0100;
    @(negedge clk);
    chk("drop.req_ack", 64'(req_ack), 64'd1);
    chk("drop.req_data_out", 64'(req_data_out), 64'h5A5A_0100);
    s_ack = 1'b0;

    // reset during ACCESS: transaction discarded, requester 0 wins afterwards
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h0000_0E00, 32'h0);
    @(negedge clk);
    chk("rst.bus_en", 64'(bus_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst.async");
    @(negedge clk);
    chk_zero("rst.held");
    req_en = '0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_zero("rst.after");
    end
    set_req(0, 1'b1, 1'b0, 32'h0000_3100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_3200, 32'h0);
    @(negedge clk);
    chk("rst.first_grant_addr", 64'(bus_addr), 64'h3100);
    s_ack = 1'b1; s_data = 32'h31;
    @(negedge clk);
    chk("rst.first_ack", 64'(req_ack), 64'd1);
    req_en = '0; s_ack = 1'b0;

    // randomized traffic against the reference model, from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1; m_have = 1'b0; m_done = 1'b0; m_g = 0; m_age = 0;
    m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    want = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      chk("rnd.bus_en", 64'(bus_en), 64'(m_have && !m_done));
      chk("rnd.bus_addr", 64'(bus_addr), (m_have && !m_done) ? 64'(m_addr) : 64'd0);
      chk("rnd.bus_we", 64'(bus_we), (m_have && !m_done) ? 64'(m_we) : 64'd0);
      chk("rnd.bus_data_in", 64'(bus_data_in), (m_have && !m_done) ? 64'(m_wdata) : 64'd0);
      e_ack = (m_have && m_done && !m_err) ? (64'd1 << m_g) : 64'd0;
      e_err = (m_have && m_done && m_err) ? (64'd1 << m_g) : 64'd0;
      e_dat = (m_have && m_done) ? (64'(m_rdata) << (32 * m_g)) : 64'd0;
      chk("rnd.req_ack", 64'(req_ack), e_ack);
      chk("rnd.req_err", 64'(req_err), e_err);
      chk("rnd.req_data_out", 64'(req_data_out), e_dat);
      for (int i = 0; i < N; i++) begin
        if (m_have && m_done && m_g == i) want[i] = 1'b0;
        else if (want[i] && m_have && !m_done && m_g == i && $urandom_range(0, 7) == 0) want[i] = 1'b0;
        if (!want[i]) begin
          if ($urandom_range(0, 1) == 1 && !(m_have && m_g == i)) begin
            want[i] = 1'b1;
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end else begin
            set_req(i, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end
        end
      end
      s_data = $urandom;
      if (m_have && !m_done) begin
        r = $urandom_range(0, 9);
        s_ack = (r <= 2) || (r == 4);
        s_err = (r == 3) || (r == 4);
      end else begin
        s_ack = 1'b0; s_err = 1'b0;
      end
      model_step();
    end
    req_en = '0; s_ack = 1'b0; s_err = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
